// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and parameter legality helper for sync_filter_bank
//
// Contents:
//   SYNC_STAGES_MIN   - shortest synchroniser chain that still resolves metastability
//   sync_stages_ok()  - returns 1 when a requested chain depth is legal
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic bit sync_stages_ok(input int stages);
        return stages >= SYNC_STAGES_MIN;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// rtl/sync_filter_ch.sv - one synchroniser channel: flop chain, debounce filter, edge pulses, sticky flag
//
// Ports:
//   clk         in   destination clock
//   rstn        in   synchronous active-low reset
//   async_in    in   asynchronous input bit
//   filt_en     in   enable the debounce filter for this channel
//   filt_len    in   FILT_W  number of extra cycles a disagreement must persist
//   evt_clr     in   write-one-to-clear for evt_sticky
//   sync_out    out  synchronised, filtered level
//   rise_pulse  out  1-cycle pulse on 0->1 of sync_out
//   fall_pulse  out  1-cycle pulse on 1->0 of sync_out
//   chg_pulse   out  1-cycle pulse on any change of sync_out
//   evt_sticky  out  latched chg_pulse until cleared
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_W      = 4,
    parameter logic [0:0] RST_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              async_in,
    input  logic              filt_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              evt_clr,
    output logic              sync_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              chg_pulse,
    output logic              evt_sticky
);

    logic [SYNC_STAGES-1:0] stage;
    logic                   level;
    logic                   level_q;
    logic [FILT_W-1:0]      cnt;
    logic                   sticky;
    logic                   s;

    assign s = stage[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage   <= {SYNC_STAGES{RST_VAL}};
            level   <= RST_VAL;
            level_q <= RST_VAL;
            cnt     <= '0;
            sticky  <= 1'b0;
        end else begin
            stage   <= {stage[SYNC_STAGES-2:0], async_in};
            level_q <= level;
            // A change landing in the clear cycle must not be lost, so set wins.
            sticky  <= (sticky & ~evt_clr) | chg_pulse;

            if (!filt_en) begin
                level <= s;
                cnt   <= '0;
            end else if (s == level) begin
                cnt <= '0;
            end else if (cnt >= filt_len) begin
                // ">=" lets a lowered filt_len take effect on the very next disagreeing edge.
                level <= s;
                cnt   <= '0;
            end else if (cnt != {FILT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sync_out   = level;
    assign rise_pulse = level & ~level_q;
    assign fall_pulse = ~level & level_q;
    assign chg_pulse  = level ^ level_q;
    assign evt_sticky = sticky;

endmodule

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - NUM_CH independent single-bit synchronisers with filter and edge pulses
//
// Ports (all per-channel vectors are NUM_CH wide, bit i = channel i):
//   clk, rstn   destination clock, synchronous active-low reset
//   async_in    asynchronous inputs
//   filt_en     per-channel filter enable (quasi-static)
//   filt_len    FILT_W shared filter length
//   evt_clr     write-one-to-clear for evt_sticky
//   sync_out    synchronised level
//   rise_pulse, fall_pulse, chg_pulse  edge pulses of sync_out
//   evt_sticky  latched chg_pulse
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_W      = 4,
    parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] async_in,
    input  logic [NUM_CH-1:0] filt_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [NUM_CH-1:0] evt_clr,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] chg_pulse,
    output logic [NUM_CH-1:0] evt_sticky
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_filter_bank: SYNC_STAGES must be >= SYNC_STAGES_MIN");
    end

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("sync_filter_bank: NUM_CH must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .RST_VAL     (RST_VAL[i])
        ) u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .async_in   (async_in[i]),
            .filt_en    (filt_en[i]),
            .filt_len   (filt_len),
            .evt_clr    (evt_clr[i]),
            .sync_out   (sync_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .chg_pulse  (chg_pulse[i]),
            .evt_sticky (evt_sticky[i])
        );
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// tb/tb_sync_filter_bank.sv - self-checking bench for sync_filter_bank
module tb_sync_filter_bank;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 4;
    localparam logic [NUM_CH-1:0] RST_VAL = '0;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NUM_CH-1:0] async_in;
    logic [NUM_CH-1:0] filt_en;
    logic [FILT_W-1:0] filt_len;
    logic [NUM_CH-1:0] evt_clr;
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic [NUM_CH-1:0] chg_pulse;
    logic [NUM_CH-1:0] evt_sticky;

    int checks = 0;
    int errors = 0;

    sync_filter_bank #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W),
        .RST_VAL     (RST_VAL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .async_in   (async_in),
        .filt_en    (filt_en),
        .filt_len   (filt_len),
        .evt_clr    (evt_clr),
        .sync_out   (sync_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .chg_pulse  (chg_pulse),
        .evt_sticky (evt_sticky)
    );

    always #5 clk = ~clk;

    // Reference model: async_in seen SYNC_STAGES edges late, then a level that
    // follows it once a disagreement has lasted filt_len+1 consecutive cycles.
    logic [NUM_CH-1:0] m_dly [SYNC_STAGES];
    logic [NUM_CH-1:0] m_lvl;
    logic [NUM_CH-1:0] m_prev;
    logic [NUM_CH-1:0] m_sticky;
    int                m_run [NUM_CH];

    task automatic check(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] seen;
        logic [NUM_CH-1:0] old_lvl;
        logic [NUM_CH-1:0] old_chg;
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_dly[k] = RST_VAL;
            m_lvl    = RST_VAL;
            m_prev   = RST_VAL;
            m_sticky = '0;
            for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
        end else begin
            seen    = m_dly[SYNC_STAGES-1];
            for (int k = SYNC_STAGES-1; k > 0; k--) m_dly[k] = m_dly[k-1];
            m_dly[0] = async_in;
            old_lvl = m_lvl;
            old_chg = m_lvl ^ m_prev;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!filt_en[i]) begin
                    m_lvl[i] = seen[i];
                    m_run[i] = 0;
                end else if (seen[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= int'(filt_len) + 1) begin
                        m_lvl[i] = seen[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_prev   = old_lvl;
            m_sticky = (m_sticky & ~evt_clr) | old_chg;
        end
    endtask

    // One clock: update the model with the inputs the DUT samples, then compare.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("m_sync", sync_out, m_lvl);
        check("m_rise", rise_pulse, m_lvl & ~m_prev);
        check("m_fall", fall_pulse, ~m_lvl & m_prev);
        check("m_chg", chg_pulse, m_lvl ^ m_prev);
        check("m_sticky", evt_sticky, m_sticky);
    endtask

    int n_chg, n_rise, n_fall;

    initial begin
        rstn = 1'b0; async_in = '1; filt_en = '0; filt_len = '0; evt_clr = '0;

        // Reset with all inputs high, then release.
        repeat (3) begin
            tick();
            check("rst_sync", sync_out, '0);
            check("rst_chg", chg_pulse, '0);
            check("rst_sticky", evt_sticky, '0);
        end
        rstn = 1'b1;
        tick(); tick();
        check("rel_pre", sync_out, '0);
        tick();
        check("rel_sync", sync_out, 4'hF);
        check("rel_rise", rise_pulse, 4'hF);
        tick();
        check("rel_sticky", evt_sticky, 4'hF);
        check("rel_rise_done", rise_pulse, '0);

        async_in = '0;
        repeat (5) tick();
        evt_clr = '1; tick(); evt_clr = '0; tick();
        check("clr_all", evt_sticky, '0);

        // Unfiltered latency on ch0.
        async_in = 4'b0001;
        tick(); tick();
        check_int("lat_early", int'(sync_out[0]), 0);
        tick();
        check_int("lat_sync", int'(sync_out[0]), 1);
        check_int("lat_rise", int'(rise_pulse[0]), 1);
        check_int("lat_fall", int'(fall_pulse[0]), 0);
        tick();
        check_int("lat_rise_1cyc", int'(rise_pulse[0]), 0);

        // Filtered ch1, filt_len=3: 3-cycle glitch is swallowed.
        filt_en = 4'b0010; filt_len = 4'd3;
        tick();
        async_in[1] = 1'b1;
        n_chg = 0;
        repeat (3) begin tick(); n_chg += int'(chg_pulse[1]); end
        async_in[1] = 1'b0;
        repeat (8) begin tick(); n_chg += int'(chg_pulse[1]); end
        check_int("glitch_pulses", n_chg, 0);

        // 5-cycle high level passes.
        async_in[1] = 1'b1;
        repeat (5) tick();
        check_int("filt_early", int'(sync_out[1]), 0);
        async_in[1] = 1'b0;
        tick();
        check_int("filt_rise", int'(rise_pulse[1]), 1);
        repeat (4) tick();
        check_int("filt_hold", int'(sync_out[1]), 1);
        tick();
        check_int("filt_fall", int'(fall_pulse[1]), 1);

        // Toggle-to-pulse on unfiltered ch2.
        n_chg = 0; n_rise = 0; n_fall = 0;
        for (int t = 0; t < 5; t++) begin
            async_in[2] = ~async_in[2];
            repeat (6) begin
                tick();
                n_chg  += int'(chg_pulse[2]);
                n_rise += int'(rise_pulse[2]);
                n_fall += int'(fall_pulse[2]);
            end
        end
        check_int("tog_chg", n_chg, 5);
        check_int("tog_rise", n_rise, 3);
        check_int("tog_fall", n_fall, 2);

        // Sticky: set wins over a same-cycle clear.
        evt_clr = '1; tick(); evt_clr = '0;
        async_in[3] = 1'b1;
        tick(); tick(); tick();
        check_int("stk_chg", int'(chg_pulse[3]), 1);
        evt_clr = 4'b1000;
        tick();
        check_int("stk_collide", int'(evt_sticky[3]), 1);
        tick();
        check_int("stk_cleared", int'(evt_sticky[3]), 0);
        evt_clr = '0;

        // Lower filt_len 7 -> 1 mid-count on ch0.
        filt_en = 4'b0001; filt_len = 4'd7;
        tick();
        async_in[0] = 1'b0;
        repeat (6) tick();
        check_int("flen_hold", int'(sync_out[0]), 1);
        filt_len = 4'd1;
        tick();
        check_int("flen_fall", int'(fall_pulse[0]), 1);

        // Reset during a pending change, inputs back at reset value.
        filt_en = '0; filt_len = '0;
        async_in[1] = 1'b1;
        tick();
        rstn = 1'b0; async_in = '0;
        tick(); tick();
        rstn = 1'b1;
        n_chg = 0;
        repeat (6) begin tick(); n_chg += $countones(chg_pulse); end
        check_int("rst_pend_quiet", n_chg, 0);

        // Reset with a channel held away from its reset value: one rise after release.
        rstn = 1'b0; async_in = 4'b0010;
        tick(); tick();
        rstn = 1'b1;
        n_rise = 0;
        repeat (6) begin tick(); n_rise += $countones(rise_pulse); end
        check_int("rst_one_rise", n_rise, 1);
        check("rst_one_level", sync_out, 4'b0010);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 3) == 0) async_in[i] = ~async_in[i];
            if ($urandom_range(0, 40) == 0) filt_en = NUM_CH'($urandom);
            if ($urandom_range(0, 40) == 0) filt_len = FILT_W'($urandom_range(0, 4));
            evt_clr = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            rstn = ($urandom_range(0, 150) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
- Multi-channel single-bit synchroniser for asynchronous or foreign-domain level and toggle signals, such as the source-side toggle of a pulse synchroniser.
- Each channel has a parametrised-depth flop chain, an optional glitch/debounce filter, edge-pulse generation (rise, fall, any-change) and a sticky event flag with write-one-to-clear.
- Sits at the boundary of the destination clock domain.
- Generalises the fixed 2-flop and toggle-to-pulse synchronisers to N channels, M stages and filtering.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, flops in each synchroniser chain (>=2; elaboration error if less).
- FILT_W, 4, width of the filter length and the per-channel filter counter.
- RST_VAL, {NUM_CH{1'b0}}, per-channel reset level for the chain, filtered level and edge history.

Ports:
- clk, in, 1, destination clock; the only clock of the block.
- rstn, in, 1, synchronous active-low reset.
- async_in, in, NUM_CH, asynchronous inputs, one per channel.
- filt_en, in, NUM_CH, per-channel filter enable (quasi-static).
- filt_len, in, FILT_W, shared filter length; disagreement must persist filt_len+1 cycles.
- evt_clr, in, NUM_CH, write-one-to-clear for evt_sticky.
- sync_out, out, NUM_CH, synchronised (and filtered) level.
- rise_pulse, out, NUM_CH, 1-cycle pulse on a 0->1 change of sync_out.
- fall_pulse, out, NUM_CH, 1-cycle pulse on a 1->0 change of sync_out.
- chg_pulse, out, NUM_CH, rise|fall; toggle-to-pulse output.
- evt_sticky, out, NUM_CH, latched chg_pulse until cleared.

Behaviour:
- All state updates on posedge clk. Reset is synchronous on rstn==0 and takes effect at the next edge.
- Reset values per channel:
  - chain stages, level and level_q = RST_VAL[i]; cnt = 0; evt_sticky = 0.
  - rise, fall and chg pulses = 0, since level == level_q.
- Chain: stage[0] <= async_in[i]; stage[k] <= stage[k-1]. Let s = stage[SYNC_STAGES-1].
- Filter, when filt_en[i]==0: level <= s; cnt <= 0.
- Filter, when filt_en[i]==1:
  - s==level: cnt <= 0.
  - s!=level and cnt >= filt_len: level <= s; cnt <= 0.
  - otherwise: cnt <= cnt+1 (saturating at all-ones).
  - The ">=" compare makes a mid-run decrease of filt_len take effect on the next disagreeing cycle.
  - filt_len==0 behaves identically to the unfiltered path.
- sync_out = level.
- Latency: an async_in change that is stable from edge E appears on sync_out after edge E+SYNC_STAGES+filt_len (filt_len taken as 0 when unfiltered). Add +1 edge of metastability uncertainty.
- Glitch rule: a disagreement shorter than filt_len+1 consecutive cycles at s never reaches level, and the counter restarts.
- Edge detection: level_q <= level.
  - rise_pulse = level & ~level_q.
  - fall_pulse = ~level & level_q.
  - chg_pulse = level ^ level_q.
  - Outputs are decoded from flops and are exactly 1 cycle wide.
- Toggle use: a source-domain toggle on async_in yields exactly one chg_pulse per toggle. Toggles must be spaced >= SYNC_STAGES+filt_len+1 destination cycles, otherwise they are merged or lost.
- Sticky flag: evt_sticky <= (evt_sticky & ~evt_clr) | chg_pulse.
  - A chg_pulse in the same cycle as evt_clr wins: the flag stays 1.
- Changing filt_en mid-operation is legal. The next edge uses the new mode; level never glitches to a value s did not hold.
- Reset mid-operation: in-flight edges are discarded and no pulse fires on reset release. After release, if async_in != RST_VAL, the normal latency applies and one edge pulse fires.
- Channels are fully independent: there are no cross-channel ordering guarantees.

Decomposition:
- Package sync_pkg: SYNC_STAGES_MIN=2 and an elaboration-check helper for the parameter legality checks.
- Sub-module sync_filter_ch: one channel (chain, filter counter, level, level_q, sticky).
- The top module generates NUM_CH instances and shares filt_len across them.

Test Plan:
- Setup for all cases: SYNC_STAGES=2, NUM_CH=4, RST_VAL=0 unless stated.
- Reset: rstn=0 for 3 cycles with async_in=4'hF. Required: all outputs 0 during reset. After release, sync_out=4'hF exactly 3 edges later, one rise_pulse per channel, evt_sticky=4'hF.
- Unfiltered latency: ch0 0->1 stable from edge 10. Required: sync_out[0]=1 after edge 12, rise_pulse[0] high one cycle, no fall_pulse.
- Filter: filt_en=1, filt_len=3.
  - A 3-cycle high glitch on ch1: no change on sync_out[1] and no pulses.
  - A 5-cycle high level: sync_out[1] rises after edge E+5 and falls after the matching delay.
- Toggle-to-pulse: toggle ch2 five times, 6 cycles apart. Required: exactly 5 chg_pulse[2] pulses, alternating rise and fall.
- Sticky collision: assert evt_clr[3] in the same cycle as chg_pulse[3]. Required: evt_sticky[3] stays 1. A following lone evt_clr clears it to 0.
- Mid-operation changes:
  - Lower filt_len from 7 to 1 while cnt=4: level updates on the next disagreeing edge.
  - Reset asserted during a pending change: no pulse after release unless async_in != 0.
